// File: rtl/vga_timing_ctrl.sv
// Programmable VGA raster sequencer: pattern-source strobes, frame-shadowed timing,
// and HSYNC/VSYNC/DE delivered one cycle behind the pixel request.
module vga_timing_ctrl #(
    parameter int HW       = 12,
    parameter int VW       = 12,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic          i_pixclk,
    input  logic          i_reset_n,
    input  logic          i_en,
    input  logic [HW-1:0] i_hm_width,
    input  logic [HW-1:0] i_hm_porch,
    input  logic [HW-1:0] i_hm_synch,
    input  logic [HW-1:0] i_hm_raw,
    input  logic [VW-1:0] i_vm_height,
    input  logic [VW-1:0] i_vm_porch,
    input  logic [VW-1:0] i_vm_synch,
    input  logic [VW-1:0] i_vm_raw,
    output logic          o_rd,
    output logic          o_newline,
    output logic          o_newframe,
    output logic [HW-1:0] o_width,
    output logic [VW-1:0] o_height,
    output logic          o_de,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_busy,
    output logic          o_cfg_err
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [HW-1:0] H_ONE = HW'(1);
    localparam logic [VW-1:0] V_ONE = VW'(1);

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [HW-1:0] hwid_q, hwid_d, hpor_q, hpor_d, hsyn_q, hsyn_d, hraw_q, hraw_d;
    logic [VW-1:0] vhgt_q, vhgt_d, vpor_q, vpor_d, vsyn_q, vsyn_d, vraw_q, vraw_d;
    logic          rd_q, rd_d, nl_q, nl_d, nf_q, nf_d, err_q, err_d;
    logic          hs_act_q, hs_act_d, vs_act_q, vs_act_d;
    logic          de_q, hsync_q, vsync_q;
    logic          cfg_ok, h_last, v_last, at_bound, load_try, running_d;

    assign cfg_ok = (i_hm_width != '0) && (i_hm_width < i_hm_porch) &&
                    (i_hm_porch < i_hm_synch) && (i_hm_synch <= i_hm_raw) &&
                    (i_vm_height != '0) && (i_vm_height < i_vm_porch) &&
                    (i_vm_porch < i_vm_synch) && (i_vm_synch <= i_vm_raw);

    assign h_last   = (h_q == hraw_q - H_ONE);
    assign v_last   = (v_q == vraw_q - V_ONE);
    assign at_bound = h_last && v_last;
    assign load_try = ((state_q == S_IDLE) && i_en) || ((state_q == S_RUN) && at_bound);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d = state_q;
        h_d     = h_q;
        v_d     = v_q;
        hwid_d  = hwid_q;
        hpor_d  = hpor_q;
        hsyn_d  = hsyn_q;
        hraw_d  = hraw_q;
        vhgt_d  = vhgt_q;
        vpor_d  = vpor_q;
        vsyn_d  = vsyn_q;
        vraw_d  = vraw_q;
        err_d   = 1'b0;

        if (load_try) begin
            if (cfg_ok) begin
                hwid_d = i_hm_width;
                hpor_d = i_hm_porch;
                hsyn_d = i_hm_synch;
                hraw_d = i_hm_raw;
                vhgt_d = i_vm_height;
                vpor_d = i_vm_porch;
                vsyn_d = i_vm_synch;
                vraw_d = i_vm_raw;
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                // Start on the last position so the first running cycle resets the source.
                if (i_en && cfg_ok) begin
                    state_d = S_RUN;
                    h_d     = i_hm_raw - H_ONE;
                    v_d     = i_vm_raw - V_ONE;
                end
            end
            S_RUN, S_DRAIN: begin
                if ((state_q == S_DRAIN) && !i_en && at_bound) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = i_en ? S_RUN : S_DRAIN;
                    h_d     = h_last ? '0 : h_q + H_ONE;
                    if (h_last) begin
                        v_d = v_last ? '0 : v_q + V_ONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Decode from the next position and next shadow so strobes leave flops.
        running_d = (state_d != S_IDLE);
        rd_d      = running_d && (h_d < hwid_d) && (v_d < vhgt_d);
        nl_d      = running_d && (h_d == hraw_d - H_ONE);
        nf_d      = nl_d && (v_d == vraw_d - V_ONE);
        hs_act_d  = running_d && (h_d >= hpor_d) && (h_d < hsyn_d);
        vs_act_d  = running_d && (v_d >= vpor_d) && (v_d < vsyn_d);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_pixclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            h_q      <= '0;
            v_q      <= '0;
            hwid_q   <= HW'(640);
            hpor_q   <= HW'(656);
            hsyn_q   <= HW'(752);
            hraw_q   <= HW'(800);
            vhgt_q   <= VW'(480);
            vpor_q   <= VW'(490);
            vsyn_q   <= VW'(492);
            vraw_q   <= VW'(525);
            rd_q     <= 1'b0;
            nl_q     <= 1'b0;
            nf_q     <= 1'b0;
            err_q    <= 1'b0;
            hs_act_q <= 1'b0;
            vs_act_q <= 1'b0;
            de_q     <= 1'b0;
            hsync_q  <= !SYNC_POL;
            vsync_q  <= !SYNC_POL;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hwid_q   <= hwid_d;
            hpor_q   <= hpor_d;
            hsyn_q   <= hsyn_d;
            hraw_q   <= hraw_d;
            vhgt_q   <= vhgt_d;
            vpor_q   <= vpor_d;
            vsyn_q   <= vsyn_d;
            vraw_q   <= vraw_d;
            rd_q     <= rd_d;
            nl_q     <= nl_d;
            nf_q     <= nf_d;
            err_q    <= err_d;
            hs_act_q <= hs_act_d;
            vs_act_q <= vs_act_d;
            de_q     <= rd_q;
            hsync_q  <= hs_act_q ? SYNC_POL : !SYNC_POL;
            vsync_q  <= vs_act_q ? SYNC_POL : !SYNC_POL;
        end
    end

    assign o_rd       = rd_q;
    assign o_newline  = nl_q;
    assign o_newframe = nf_q;
    assign o_width    = hwid_q;
    assign o_height   = vhgt_q;
    assign o_de       = de_q;
    assign o_hsync    = hsync_q;
    assign o_vsync    = vsync_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_cfg_err  = err_q;

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Bench for vga_timing_ctrl: a frame/linear-position model checked every cycle,
// directed scenarios pinned by hand-computed counts, then randomised enable/config traffic.
`timescale 1ns/1ps
module tb_vga_timing_ctrl;
    localparam int HW       = 12;
    localparam int VW       = 12;
    localparam bit SYNC_POL = 1'b0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [HW-1:0] hm_width, hm_porch, hm_synch, hm_raw;
    logic [VW-1:0] vm_height, vm_porch, vm_synch, vm_raw;
    logic          rd, newline, newframe, de, hsync, vsync, busy, cfg_err;
    logic [HW-1:0] width;
    logic [VW-1:0] height;

    always #5 clk = ~clk;

    vga_timing_ctrl #(.HW(HW), .VW(VW), .SYNC_POL(SYNC_POL)) dut (
        .i_pixclk    (clk),
        .i_reset_n   (rst_n),
        .i_en        (en),
        .i_hm_width  (hm_width),
        .i_hm_porch  (hm_porch),
        .i_hm_synch  (hm_synch),
        .i_hm_raw    (hm_raw),
        .i_vm_height (vm_height),
        .i_vm_porch  (vm_porch),
        .i_vm_synch  (vm_synch),
        .i_vm_raw    (vm_raw),
        .o_rd        (rd),
        .o_newline   (newline),
        .o_newframe  (newframe),
        .o_width     (width),
        .o_height    (height),
        .o_de        (de),
        .o_hsync     (hsync),
        .o_vsync     (vsync),
        .o_busy      (busy),
        .o_cfg_err   (cfg_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int w; int hp; int hs; int hr;
        int h; int vp; int vs; int vr;
    } cfg_t;
    typedef enum int {M_IDLE, M_RUN, M_DRAIN} mode_t;
    typedef struct {
        int n_rd; int n_nl; int n_nf; int n_hs; int n_vs; int last_nf;
    } cnt_t;

    cfg_t  m_cfg;
    mode_t m_mode;
    int    m_pos;
    bit    e_rd, e_nl, e_nf, e_de, e_err, e_hs_act, e_vs_act, e_hs_out, e_vs_out;

    function automatic cfg_t reset_cfg();
        cfg_t c;
        c.w = 640; c.hp = 656; c.hs = 752; c.hr = 800;
        c.h = 480; c.vp = 490; c.vs = 492; c.vr = 525;
        return c;
    endfunction

    function automatic cfg_t cfg_inputs();
        cfg_t c;
        c.w = int'(hm_width);  c.hp = int'(hm_porch); c.hs = int'(hm_synch); c.hr = int'(hm_raw);
        c.h = int'(vm_height); c.vp = int'(vm_porch); c.vs = int'(vm_synch); c.vr = int'(vm_raw);
        return c;
    endfunction

    function automatic bit cfg_valid(input cfg_t c);
        return (c.w > 0) && (c.w < c.hp) && (c.hp < c.hs) && (c.hs <= c.hr) &&
               (c.h > 0) && (c.h < c.vp) && (c.vp < c.vs) && (c.vs <= c.vr);
    endfunction

    task automatic model_reset();
        m_cfg  = reset_cfg();
        m_mode = M_IDLE;
        m_pos  = 0;
        {e_rd, e_nl, e_nf, e_de, e_err, e_hs_act, e_vs_act, e_hs_out, e_vs_out} = '0;
    endtask

    // One pixel-clock step: raster is a linear position 0..HRAW*VRAW-1 within the frame.
    task automatic model_step();
        cfg_t cin;
        bit   ok, boundary, tries;
        int   hpos, vpos;
        cin      = cfg_inputs();
        ok       = cfg_valid(cin);
        boundary = (m_mode != M_IDLE) && (m_pos == m_cfg.hr * m_cfg.vr - 1);
        tries    = ((m_mode == M_IDLE) && en) || ((m_mode == M_RUN) && boundary);
        e_err    = tries && !ok;
        if (tries && ok) m_cfg = cin;
        e_de     = e_rd;
        e_hs_out = e_hs_act;
        e_vs_out = e_vs_act;
        if (m_mode == M_IDLE) begin
            if (en && ok) begin
                m_mode = M_RUN;
                m_pos  = m_cfg.hr * m_cfg.vr - 1;
            end
        end else if ((m_mode == M_DRAIN) && !en && boundary) begin
            m_mode = M_IDLE;
        end else begin
            m_pos  = boundary ? 0 : m_pos + 1;
            m_mode = en ? M_RUN : M_DRAIN;
        end
        if (m_mode == M_IDLE) begin
            {e_rd, e_nl, e_nf, e_hs_act, e_vs_act} = '0;
        end else begin
            hpos     = m_pos % m_cfg.hr;
            vpos     = m_pos / m_cfg.hr;
            e_rd     = (hpos < m_cfg.w) && (vpos < m_cfg.h);
            e_nl     = (hpos == m_cfg.hr - 1);
            e_nf     = (m_pos == m_cfg.hr * m_cfg.vr - 1);
            e_hs_act = (hpos >= m_cfg.hp) && (hpos < m_cfg.hs);
            e_vs_act = (vpos >= m_cfg.vp) && (vpos < m_cfg.vs);
        end
    endtask

    task automatic compare_all();
        check("rd", rd, e_rd);
        check("newline", newline, e_nl);
        check("newframe", newframe, e_nf);
        check("de", de, e_de);
        check("hsync", hsync, e_hs_out ? SYNC_POL : !SYNC_POL);
        check("vsync", vsync, e_vs_out ? SYNC_POL : !SYNC_POL);
        check("busy", busy, m_mode != M_IDLE);
        check("cfg_err", cfg_err, e_err);
        check("width", width, m_cfg.w);
        check("height", height, m_cfg.h);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) model_reset();
            else model_step();
            #1;
            compare_all();
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_small();
        hm_width = 12'd8;  hm_porch = 12'd10; hm_synch = 12'd12; hm_raw = 12'd16;
        vm_height = 12'd4; vm_porch = 12'd5;  vm_synch = 12'd6;  vm_raw = 12'd8;
    endtask

    task automatic drive_random_cfg();
        int w, hp, hs, hr, h, vp, vs, vr;
        w  = int'($urandom_range(1, 6));
        hp = w + int'($urandom_range(1, 3));
        hs = hp + int'($urandom_range(1, 3));
        hr = hs + int'($urandom_range(0, 3));
        h  = int'($urandom_range(1, 4));
        vp = h + int'($urandom_range(1, 2));
        vs = vp + int'($urandom_range(1, 2));
        vr = vs + int'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) hs = hp;
        else if ($urandom_range(0, 19) == 0) vr = vs - 1;
        hm_width = HW'(w);  hm_porch = HW'(hp); hm_synch = HW'(hs); hm_raw = HW'(hr);
        vm_height = VW'(h); vm_porch = VW'(vp); vm_synch = VW'(vs); vm_raw = VW'(vr);
    endtask

    // which: 0 = newframe, 1 = newline, 2 = rd
    task automatic wait_flag(input int which, input int budget, input string name);
        logic found;
        found = 1'b0;
        for (int i = 0; i < budget && !found; i++) begin
            @(posedge clk); #2;
            case (which)
                0:       found = newframe;
                1:       found = newline;
                default: found = rd;
            endcase
        end
        check(name, found, 1'b1);
    endtask

    task automatic count_cycles(input int n, output cnt_t c);
        c.n_rd = 0; c.n_nl = 0; c.n_nf = 0; c.n_hs = 0; c.n_vs = 0; c.last_nf = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #2;
            c.n_rd   += int'(rd);
            c.n_nl   += int'(newline);
            c.n_nf   += int'(newframe);
            c.n_hs   += (hsync == SYNC_POL) ? 1 : 0;
            c.n_vs   += (vsync == SYNC_POL) ? 1 : 0;
            c.last_nf = int'(newframe);
        end
    endtask

    initial begin
        cnt_t c;
        int   gap;
        logic busy_low;

        rst_n = 1'b0;
        en    = 1'b0;
        set_small();
        repeat (3) @(negedge clk);
        check("rst_width", width, 640);
        check("rst_height", height, 480);
        check("rst_hsync", hsync, !SYNC_POL);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("idle_busy", busy, 1'b0);
        check("idle_width", width, 640);

        // Start latency
        @(negedge clk); en = 1'b1;
        @(posedge clk); #2;
        check("start_newline", newline, 1'b1);
        check("start_newframe", newframe, 1'b1);
        check("start_rd", rd, 1'b0);
        check("start_busy", busy, 1'b1);
        check("start_width", width, 8);
        @(posedge clk); #2;
        check("first_rd", rd, 1'b1);
        check("first_de", de, 1'b0);
        @(posedge clk); #2;
        check("first_de_rise", de, 1'b1);

        // One full small frame
        wait_flag(0, 200, "wait_frame_end");
        count_cycles(128, c);
        check("frame_rd", c.n_rd, 32);
        check("frame_newline", c.n_nl, 8);
        check("frame_newframe", c.n_nf, 1);
        check("frame_period", c.last_nf, 1);
        check("frame_hsync", c.n_hs, 16);
        check("frame_vsync", c.n_vs, 16);

        // Width written mid-frame takes effect only after the boundary
        wait_flag(1, 40, "wait_line0");
        wait_flag(1, 40, "wait_line1");
        @(negedge clk); hm_width = 12'd6;
        wait_flag(0, 200, "wait_frame_end_w");
        check("width_held", width, 8);
        count_cycles(128, c);
        check("width_new", width, 6);
        check("frame_rd_w6", c.n_rd, 24);
        check("frame_w6_period", c.last_nf, 1);

        // Invalid config at a boundary
        @(negedge clk); hm_porch = 12'd12;
        @(posedge clk); #2;
        check("cfg_err_pulse", cfg_err, 1'b1);
        check("cfg_err_width", width, 6);
        @(posedge clk); #2;
        check("cfg_err_clear", cfg_err, 1'b0);
        count_cycles(126, c);
        check("err_frame_rd", c.n_rd, 22);
        check("err_frame_end", c.last_nf, 1);
        @(negedge clk); hm_porch = 12'd10;
        @(posedge clk); #2;
        check("reload_no_err", cfg_err, 1'b0);

        // Drain to idle
        wait_flag(1, 40, "wait_drain_line");
        @(negedge clk); en = 1'b0;
        wait_flag(0, 200, "wait_drain_frame");
        check("drain_busy_boundary", busy, 1'b1);
        @(posedge clk); #2;
        check("drain_idle_busy", busy, 1'b0);
        check("drain_idle_rd", rd, 1'b0);
        check("drain_idle_newline", newline, 1'b0);

        // Invalid config while idle with enable
        @(negedge clk); hm_porch = 12'd12; en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #2;
            check("idle_cfg_err", cfg_err, 1'b1);
            check("idle_err_busy", busy, 1'b0);
        end
        @(negedge clk); hm_porch = 12'd10;
        @(posedge clk); #2;
        check("restart_busy", busy, 1'b1);
        check("restart_newframe", newframe, 1'b1);
        check("restart_err", cfg_err, 1'b0);

        // Drop and re-raise enable inside a line: cadence unbroken
        wait_flag(1, 40, "wait_cadence_line");
        gap      = 0;
        busy_low = 1'b0;
        for (int i = 1; i <= 40 && gap == 0; i++) begin
            @(negedge clk);
            if (i == 1) en = 1'b0;
            if (i == 5) en = 1'b1;
            @(posedge clk); #2;
            if (!busy) busy_low = 1'b1;
            if (newline) gap = i;
        end
        check("drain_resume_gap", gap, 16);
        check("drain_resume_busy", busy_low, 1'b0);

        // Randomised enable and configuration traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 39) == 0) en = ~en;
            if ($urandom_range(0, 59) == 0) drive_random_cfg();
        end

        // Asynchronous reset mid-line
        @(negedge clk);
        set_small();
        en = 1'b1;
        wait_flag(2, 400, "wait_rd_before_reset");
        #1 rst_n = 1'b0;
        #1;
        check("arst_rd", rd, 1'b0);
        check("arst_newline", newline, 1'b0);
        check("arst_newframe", newframe, 1'b0);
        check("arst_de", de, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_cfg_err", cfg_err, 1'b0);
        check("arst_hsync", hsync, !SYNC_POL);
        check("arst_vsync", vsync, !SYNC_POL);
        check("arst_width", width, 640);
        check("arst_height", height, 480);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #2;
        check("rst_restart_newline", newline, 1'b1);
        check("rst_restart_newframe", newframe, 1'b1);
        repeat (50) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
